// File: rtl/wdt_pkg.sv
// wdt_multi shared definitions: register offsets,
// channel stride and channel state encoding.
package wdt_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_LOAD   = 5'h04;
  localparam logic [4:0] OFF_KICK   = 5'h08;
  localparam logic [4:0] OFF_CNT    = 5'h0C;
  localparam logic [4:0] OFF_WINDOW = 5'h10;

  localparam logic [7:0] ADDR_STATUS   = 8'h80;
  localparam logic [7:0] ADDR_PRESCALE = 8'h84;
  localparam logic [7:0] CH_STRIDE     = 8'h20;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } ch_state_t;

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: control regs, down-counter, IDLE/RUN FSM.
// Optional kick window enabled by WDT_WINDOW_EN.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int              CNT_W    = 32,
  parameter logic [31:0]     KICK_KEY = 32'h0000_A55A,
  parameter logic [CNT_W-1:0] LOAD_RST = '1
) (
  input  logic             clk2,
  input  logic             rst2,
  input  logic             tick,
  input  logic             ctrl_we,
  input  logic             load_we,
  input  logic             kick_we,
`ifdef WDT_WINDOW_EN
  input  logic             window_we,
  output logic [CNT_W-1:0] window,
`endif
  input  logic [31:0]      wdata,
  input  logic             status_bit,
  output logic             timeout,
  output logic             strike,
  output logic             en,
  output logic             rst_en,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = 1;

  ch_state_t state;
  logic      key_ok;
  logic      kick_ok;
  logic      viol;
  logic      tick_to;

  assign key_ok = kick_we && (wdata == KICK_KEY);

`ifdef WDT_WINDOW_EN
  assign viol    = key_ok && (state == ST_RUN) && (cnt > window);
  assign kick_ok = key_ok && !viol;
`else
  assign viol    = 1'b0;
  assign kick_ok = key_ok;
`endif

  // a kick on the expiry tick suppresses the timeout
  assign tick_to = (state == ST_RUN) && tick
                && (cnt == '0) && !kick_ok;
  assign timeout = tick_to || viol;
  assign strike  = timeout && status_bit && rst_en;

  // control registers and channel state machine
  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      state  <= ST_IDLE;
      en     <= 1'b0;
      rst_en <= 1'b0;
      load   <= LOAD_RST;
      cnt    <= LOAD_RST;
`ifdef WDT_WINDOW_EN
      window <= '0;
`endif
    end else begin
      if (ctrl_we) begin
        en     <= wdata[0];
        rst_en <= wdata[1];
      end
      if (load_we) load <= wdata[CNT_W-1:0];
`ifdef WDT_WINDOW_EN
      if (window_we) window <= wdata[CNT_W-1:0];
`endif
      unique case (state)
        ST_IDLE: begin
          cnt <= load;
          if (ctrl_we && wdata[0]) state <= ST_RUN;
        end
        ST_RUN: begin
          if (ctrl_we && !wdata[0]) begin
            state <= ST_IDLE;
            cnt   <= load;
          end else if (kick_ok || timeout) begin
            cnt <= load;
          end else if (tick) begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog top: prescaler, W1C status, read mux,
// sticky reset request. Optional feature macro: WDT_WINDOW_EN.
module wdt_multi
  import wdt_pkg::*;
#(
  parameter int               NUM_CH   = 4,
  parameter int               CNT_W    = 32,
  parameter logic [31:0]      KICK_KEY = 32'h0000_A55A,
  parameter logic [CNT_W-1:0] LOAD_RST = '1
) (
  input  logic              clk2,
  input  logic              rst2,
  input  logic              reg_wen,
  input  logic              reg_ren,
  input  logic [7:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_rvalid,
  output logic [NUM_CH-1:0] wdt_irq_ch,
  output logic              wdt_irq,
  output logic              wdt_rst_req
);

  logic [15:0]       prescale;
  logic [15:0]       psc_cnt;
  logic              tick;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] status_nxt;
  logic [NUM_CH-1:0] w1c;
  logic              sts_we;
  logic              psc_we;
  logic [31:0]       rd_val;

  logic [NUM_CH-1:0] ctrl_we;
  logic [NUM_CH-1:0] load_we;
  logic [NUM_CH-1:0] kick_we;
  logic [NUM_CH-1:0] to_vec;
  logic [NUM_CH-1:0] strike_vec;
  logic [NUM_CH-1:0] en_v;
  logic [NUM_CH-1:0] rst_en_v;
  logic [CNT_W-1:0]  load_v [NUM_CH];
  logic [CNT_W-1:0]  cnt_v  [NUM_CH];
`ifdef WDT_WINDOW_EN
  logic [NUM_CH-1:0] window_we;
  logic [CNT_W-1:0]  window_v [NUM_CH];
`endif

  // >= rather than == so a lowered PRESCALE never waits a full wrap
  assign tick   = (psc_cnt >= prescale);
  assign sts_we = reg_wen && (reg_addr == ADDR_STATUS);
  assign psc_we = reg_wen && (reg_addr == ADDR_PRESCALE);
  assign w1c    = sts_we ? reg_wdata[NUM_CH-1:0] : '0;
  // a new timeout wins over a same-cycle clear
  assign status_nxt = (status & ~w1c) | to_vec;

  // per-channel write strobe decode
  always_comb begin
    logic [7:0] base;
    ctrl_we = '0;
    load_we = '0;
    kick_we = '0;
`ifdef WDT_WINDOW_EN
    window_we = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      base = CH_STRIDE * 8'(c);
      if (reg_wen && ({reg_addr[7:5], 5'b0} == base)) begin
        ctrl_we[c] = (reg_addr[4:0] == OFF_CTRL);
        load_we[c] = (reg_addr[4:0] == OFF_LOAD);
        kick_we[c] = (reg_addr[4:0] == OFF_KICK);
`ifdef WDT_WINDOW_EN
        window_we[c] = (reg_addr[4:0] == OFF_WINDOW);
`endif
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wdt_channel #(
      .CNT_W    (CNT_W),
      .KICK_KEY (KICK_KEY),
      .LOAD_RST (LOAD_RST)
    ) u_ch (
      .clk2       (clk2),
      .rst2       (rst2),
      .tick       (tick),
      .ctrl_we    (ctrl_we[c]),
      .load_we    (load_we[c]),
      .kick_we    (kick_we[c]),
`ifdef WDT_WINDOW_EN
      .window_we  (window_we[c]),
      .window     (window_v[c]),
`endif
      .wdata      (reg_wdata),
      .status_bit (status[c]),
      .timeout    (to_vec[c]),
      .strike     (strike_vec[c]),
      .en         (en_v[c]),
      .rst_en     (rst_en_v[c]),
      .load       (load_v[c]),
      .cnt        (cnt_v[c])
    );
  end

  // read mux; unmapped and absent channels read 0
  always_comb begin
    logic [7:0] base;
    rd_val = '0;
    if (reg_addr == ADDR_STATUS) begin
      rd_val = 32'(status);
    end else if (reg_addr == ADDR_PRESCALE) begin
      rd_val = 32'(prescale);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        base = CH_STRIDE * 8'(c);
        if ({reg_addr[7:5], 5'b0} == base) begin
          unique case (reg_addr[4:0])
            OFF_CTRL:   rd_val = {30'b0, rst_en_v[c], en_v[c]};
            OFF_LOAD:   rd_val = 32'(load_v[c]);
            OFF_CNT:    rd_val = 32'(cnt_v[c]);
`ifdef WDT_WINDOW_EN
            OFF_WINDOW: rd_val = 32'(window_v[c]);
`endif
            default:    rd_val = '0;
          endcase
        end
      end
    end
  end

  // prescaler, status, interrupts, reset request, read port
  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      prescale    <= '0;
      psc_cnt     <= '0;
      status      <= '0;
      wdt_irq     <= 1'b0;
      wdt_rst_req <= 1'b0;
      reg_rdata   <= '0;
      reg_rvalid  <= 1'b0;
    end else begin
      if (psc_we) prescale <= reg_wdata[15:0];
      psc_cnt     <= tick ? '0 : psc_cnt + 16'd1;
      status      <= status_nxt;
      wdt_irq     <= |status_nxt;
      wdt_rst_req <= wdt_rst_req | (|strike_vec);
      reg_rvalid  <= reg_ren;
      if (reg_ren) reg_rdata <= rd_val;
    end
  end

  assign wdt_irq_ch = status;

endmodule

// File: tb/tb_wdt_multi.sv
// Directed self-checking bench for wdt_multi (NUM_CH=2).
// Expected values are hand-computed cycle counts.
module tb_wdt_multi;

  localparam logic [31:0] KEY = 32'h0000_A55A;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk2 = 1'b0;
  logic        rst2 = 1'b1;
  logic        reg_wen = 1'b0;
  logic        reg_ren = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic [1:0]  wdt_irq_ch;
  logic        wdt_irq;
  logic        wdt_rst_req;

  int n_chk = 0;
  int n_fail = 0;

  wdt_multi #(.NUM_CH(2)) dut (
    .clk2        (clk2),
    .rst2        (rst2),
    .reg_wen     (reg_wen),
    .reg_ren     (reg_ren),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .reg_rvalid  (reg_rvalid),
    .wdt_irq_ch  (wdt_irq_ch),
    .wdt_irq     (wdt_irq),
    .wdt_rst_req (wdt_rst_req)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk2);
    reg_wen = 1'b1;
    reg_addr = a;
    reg_wdata = d;
    @(posedge clk2);
    #1;
    reg_wen = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp,
                    input string tag);
    @(negedge clk2);
    reg_ren = 1'b1;
    reg_addr = a;
    @(posedge clk2);
    #1;
    reg_ren = 1'b0;
    chk({tag, "_rvalid"}, 32'(reg_rvalid), 32'd1);
    chk(tag, reg_rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk2);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk2);
    rst2 = 1'b1;
    @(negedge clk2);
    rst2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;

    // reset values
    #12;
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_rvalid", 32'(reg_rvalid), 32'd0);
    chk("rst_irq_ch", 32'(wdt_irq_ch), 32'd0);
    chk("rst_irq", 32'(wdt_irq), 32'd0);
    chk("rst_req", 32'(wdt_rst_req), 32'd0);
    @(negedge clk2);
    rst2 = 1'b0;
    rd(8'h80, 32'd0, "rst_status");
    rd(8'h84, 32'd0, "rst_prescale");
    rd(8'h00, 32'd0, "rst_ctrl0");
    rd(8'h04, ONES, "rst_load0");
    rd(8'h0C, ONES, "rst_cnt0");

    // basic timeout, LOAD=3, PRESCALE=0
    do_reset();
    wr(8'h04, 32'd3);
    wr(8'h00, 32'd1);
    idle(3);
    chk("a_pre_to", 32'(wdt_irq_ch), 32'd0);
    idle(1);
    chk("a_to_ch", 32'(wdt_irq_ch), 32'd1);
    chk("a_to_irq", 32'(wdt_irq), 32'd1);
    rd(8'h0C, 32'd3, "a_cnt_reload");
    idle(4);
    chk("a_no_esc", 32'(wdt_rst_req), 32'd0);
    chk("a_status_held", 32'(wdt_irq_ch), 32'd1);

    // keyed kicks, including kick on the expiry tick
    do_reset();
    wr(8'h04, 32'd3);
    wr(8'h00, 32'd1);
    for (int i = 0; i < 5; i++) begin
      idle(3);
      wr(8'h08, KEY);
    end
    chk("b_kick_wins", 32'(wdt_irq_ch), 32'd0);
    for (int i = 0; i < 33; i++) begin
      idle(2);
      wr(8'h08, KEY);
    end
    chk("b_kick3_ch", 32'(wdt_irq_ch), 32'd0);
    chk("b_kick3_irq", 32'(wdt_irq), 32'd0);
    wr(8'h08, 32'h0000_1234);
    idle(2);
    chk("b_badkey_pre", 32'(wdt_irq_ch), 32'd0);
    idle(1);
    chk("b_badkey_to", 32'(wdt_irq_ch), 32'd1);
    chk("b_badkey_irq", 32'(wdt_irq), 32'd1);

    // escalation with RST_EN=1, LOAD=1
    do_reset();
    wr(8'h04, 32'd1);
    wr(8'h00, 32'd3);
    idle(2);
    chk("c_first_to", 32'(wdt_irq_ch), 32'd1);
    chk("c_first_req", 32'(wdt_rst_req), 32'd0);
    idle(2);
    chk("c_second_req", 32'(wdt_rst_req), 32'd1);
    wr(8'h80, 32'd1);
    chk("c_w1c", 32'(wdt_irq_ch), 32'd0);
    chk("c_w1c_irq", 32'(wdt_irq), 32'd0);
    chk("c_req_sticky", 32'(wdt_rst_req), 32'd1);
    wr(8'h00, 32'd0);
    idle(3);
    chk("c_req_sticky2", 32'(wdt_rst_req), 32'd1);
    rd(8'h00, 32'd0, "c_ctrl_off");
    @(negedge clk2);
    rst2 = 1'b1;
    #1;
    chk("c_async_req", 32'(wdt_rst_req), 32'd0);
    chk("c_async_ch", 32'(wdt_irq_ch), 32'd0);
    @(negedge clk2);
    rst2 = 1'b0;
    rd(8'h04, ONES, "c_load_rst");
    rd(8'h0C, ONES, "c_cnt_rst");

    // PRESCALE=4, LOAD=1; W1C against a same-cycle timeout
    do_reset();
    wr(8'h84, 32'd4);
    wr(8'h04, 32'd1);
    idle(3);
    wr(8'h00, 32'd1);
    k = 0;
    while (wdt_irq_ch[0] == 1'b0 && k < 20) begin
      idle(1);
      k++;
    end
    chk("d_latency", 32'(k), 32'd10);
    wr(8'h80, 32'd1);
    chk("d_w1c", 32'(wdt_irq_ch), 32'd0);
    idle(8);
    chk("d_pre_to", 32'(wdt_irq_ch), 32'd0);
    wr(8'h80, 32'd1);
    chk("d_set_wins", 32'(wdt_irq_ch), 32'd1);
    chk("d_set_irq", 32'(wdt_irq), 32'd1);
    rd(8'h84, 32'd4, "d_prescale");

    // two channels, LOAD 2 and 5
    do_reset();
    wr(8'h04, 32'd2);
    wr(8'h24, 32'd5);
    wr(8'h00, 32'd1);
    wr(8'h20, 32'd1);
    idle(1);
    chk("e_none", 32'(wdt_irq_ch), 32'd0);
    idle(1);
    chk("e_ch0", 32'(wdt_irq_ch), 32'd1);
    idle(3);
    chk("e_ch0_only", 32'(wdt_irq_ch), 32'd1);
    idle(1);
    chk("e_both", 32'(wdt_irq_ch), 32'd3);
    rd(8'h80, 32'd3, "e_status_rd");
    rd(8'h20, 32'd1, "e_ctrl1");
    rd(8'h28, 32'd0, "e_kick_rd");
    rd(8'h8C, 32'd0, "e_unmapped");
    wr(8'h64, 32'd7);
    rd(8'h64, 32'd0, "e_absent_ch");
    rd(8'h60, 32'd0, "e_absent_ctrl");
    chk("e_no_esc", 32'(wdt_rst_req), 32'd0);

    // LOAD=0 in RUN times out on every tick
    do_reset();
    wr(8'h04, 32'd0);
    wr(8'h00, 32'd3);
    idle(1);
    chk("f_to1", 32'(wdt_irq_ch), 32'd1);
    chk("f_req1", 32'(wdt_rst_req), 32'd0);
    idle(1);
    chk("f_req2", 32'(wdt_rst_req), 32'd1);

`ifdef WDT_WINDOW_EN
    // windowed kick
    do_reset();
    wr(8'h04, 32'd10);
    wr(8'h10, 32'd4);
    wr(8'h00, 32'd1);
    idle(3);
    wr(8'h08, KEY);
    chk("g_violation", 32'(wdt_irq_ch), 32'd1);
    wr(8'h80, 32'd1);
    idle(6);
    wr(8'h08, KEY);
    chk("g_ok_kick", 32'(wdt_irq_ch), 32'd0);
    rd(8'h0C, 32'd10, "g_cnt_reload");
    rd(8'h10, 32'd4, "g_window_rd");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
